// File: rtl/gamma_lut_ctrl_pkg.sv
// gamma_lut_ctrl_pkg: shared state encoding, channel codes and LUT depth for the gamma LUT controller
package gamma_lut_ctrl_pkg;
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_PENDING, ST_SWAP} state_t;
  typedef enum logic [1:0] {CH_R = 2'd0, CH_G = 2'd1, CH_B = 2'd2, CH_RSVD = 2'd3} lut_ch_t;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned LUT_DEPTH = 1 << DEFAULT_DATA_WIDTH;
  function automatic int unsigned lut_depth(input int unsigned w);
    return 1 << w;
  endfunction
endpackage

// File: rtl/gamma_lut_init_cnt.sv
// gamma_lut_init_cnt: bank/channel/address walker for identity-table loading, address fastest
module gamma_lut_init_cnt
  import gamma_lut_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic         bank,
  output logic [1:0]   ch,
  output logic [W-1:0] addr,
  output logic         last
);
  logic         bank_q, bank_d;
  logic [1:0]   ch_q, ch_d;
  logic [W-1:0] addr_q, addr_d;
  logic         addr_end, ch_end;
  always_comb begin
    addr_end = addr_q == W'(lut_depth(W) - 1);
    ch_end   = ch_q == CH_B;
    addr_d   = en ? addr_q + 1'b1 : addr_q;
    ch_d     = (en && addr_end) ? (ch_end ? 2'd0 : ch_q + 2'd1) : ch_q;
    bank_d   = (en && addr_end && ch_end) ? ~bank_q : bank_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q <= 1'b0;
      ch_q   <= 2'd0;
      addr_q <= '0;
    end else begin
      bank_q <= bank_d;
      ch_q   <= ch_d;
      addr_q <= addr_d;
    end
  end
  assign bank = bank_q;
  assign ch   = ch_q;
  assign addr = addr_q;
  assign last = bank_q && ch_end && addr_end;
endmodule

// File: rtl/gamma_lut_ctrl.sv
// gamma_lut_ctrl: double-buffered gamma LUT loader with identity init and frame-synchronous bank swap
module gamma_lut_ctrl
  import gamma_lut_ctrl_pkg::*;
#(
  parameter int G_DATA_WIDTH = 8
) (
  input  logic                    SYS_CLK_I,
  input  logic                    RESET_I,
  input  logic                    FRAME_START_I,
  input  logic                    HOST_WR_I,
  input  logic [1:0]              HOST_CH_I,
  input  logic [G_DATA_WIDTH-1:0] HOST_ADDR_I,
  input  logic [G_DATA_WIDTH-1:0] HOST_DATA_I,
  input  logic                    HOST_COMMIT_I,
  output logic                    HOST_READY_O,
  output logic                    LUT_WE_O,
  output logic                    LUT_BANK_O,
  output logic [1:0]              LUT_CH_O,
  output logic [G_DATA_WIDTH-1:0] LUT_ADDR_O,
  output logic [G_DATA_WIDTH-1:0] LUT_DATA_O,
  output logic                    ACTIVE_BANK_O,
  output logic                    COMMIT_PENDING_O,
  output logic                    SWAP_O,
  output logic                    INIT_DONE_O
);
  localparam int W = G_DATA_WIDTH;
  state_t       state_q, state_d;
  logic         active_q, active_d, swap_q, swap_d, pend_q, pend_d;
  logic         ready_q, ready_d, done_q, done_d, we_q, we_d, wbank_q, wbank_d;
  logic [1:0]   ch_q, ch_d;
  logic [W-1:0] addr_q, addr_d, data_q, data_d;
  logic         cnt_bank, cnt_last;
  logic [1:0]   cnt_ch;
  logic [W-1:0] cnt_addr;
  gamma_lut_init_cnt #(.W(W)) u_cnt (
    .clk (SYS_CLK_I),
    .rst (RESET_I),
    .en  (state_q == ST_INIT),
    .bank(cnt_bank),
    .ch  (cnt_ch),
    .addr(cnt_addr),
    .last(cnt_last)
  );
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    swap_d   = 1'b0;
    pend_d   = 1'b0;
    ready_d  = 1'b0;
    done_d   = done_q;
    we_d     = 1'b0;
    wbank_d  = wbank_q;
    ch_d     = ch_q;
    addr_d   = addr_q;
    data_d   = data_q;
    case (state_q)
      ST_INIT: begin
        we_d    = 1'b1;
        wbank_d = cnt_bank;
        ch_d    = cnt_ch;
        addr_d  = cnt_addr;
        data_d  = cnt_addr;
        if (cnt_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end
      end
      ST_IDLE: begin
        ready_d = !HOST_COMMIT_I;
        if (HOST_WR_I && HOST_CH_I != CH_RSVD) begin
          we_d    = 1'b1;
          wbank_d = ~active_q;
          ch_d    = HOST_CH_I;
          addr_d  = HOST_ADDR_I;
          data_d  = HOST_DATA_I;
        end
        if (HOST_COMMIT_I) begin
          state_d = ST_PENDING;
          pend_d  = 1'b1;
        end
      end
      ST_PENDING: begin
        pend_d = !FRAME_START_I;
        if (FRAME_START_I) begin
          state_d  = ST_SWAP;
          active_d = ~active_q;
          swap_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge SYS_CLK_I) begin
    if (RESET_I) begin
      state_q  <= ST_INIT;
      active_q <= 1'b0;
      swap_q   <= 1'b0;
      pend_q   <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      wbank_q  <= 1'b0;
      ch_q     <= 2'd0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      swap_q   <= swap_d;
      pend_q   <= pend_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      we_q     <= we_d;
      wbank_q  <= wbank_d;
      ch_q     <= ch_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end
  assign HOST_READY_O     = ready_q;
  assign LUT_WE_O         = we_q;
  assign LUT_BANK_O       = wbank_q;
  assign LUT_CH_O         = ch_q;
  assign LUT_ADDR_O       = addr_q;
  assign LUT_DATA_O       = data_q;
  assign ACTIVE_BANK_O    = active_q;
  assign COMMIT_PENDING_O = pend_q;
  assign SWAP_O           = swap_q;
  assign INIT_DONE_O      = done_q;
endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// tb_gamma_lut_ctrl: directed self-checking bench for gamma_lut_ctrl at width 8
module tb_gamma_lut_ctrl;
  logic       clk = 1'b0, rst = 1'b1, frame_start = 1'b0, host_wr = 1'b0, host_commit = 1'b0;
  logic [1:0] host_ch = 2'd0;
  logic [7:0] host_addr = 8'd0, host_data = 8'd0;
  logic       host_ready, lut_we, lut_bank, active_bank, commit_pending, swap, init_done;
  logic [1:0] lut_ch;
  logic [7:0] lut_addr, lut_data;
  int         passed = 0, total = 0;
  gamma_lut_ctrl #(.G_DATA_WIDTH(8)) dut (
    .SYS_CLK_I       (clk),
    .RESET_I         (rst),
    .FRAME_START_I   (frame_start),
    .HOST_WR_I       (host_wr),
    .HOST_CH_I       (host_ch),
    .HOST_ADDR_I     (host_addr),
    .HOST_DATA_I     (host_data),
    .HOST_COMMIT_I   (host_commit),
    .HOST_READY_O    (host_ready),
    .LUT_WE_O        (lut_we),
    .LUT_BANK_O      (lut_bank),
    .LUT_CH_O        (lut_ch),
    .LUT_ADDR_O      (lut_addr),
    .LUT_DATA_O      (lut_data),
    .ACTIVE_BANK_O   (active_bank),
    .COMMIT_PENDING_O(commit_pending),
    .SWAP_O          (swap),
    .INIT_DONE_O     (init_done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic host_write(input logic [1:0] c, input logic [7:0] a, input logic [7:0] d);
    host_wr = 1'b1;
    host_ch = c;
    host_addr = a;
    host_data = d;
    tick();
    host_wr = 1'b0;
  endtask
  // Walks the expected identity sequence: bank, then channel, then address fastest.
  task automatic run_init(input string tag);
    int idx = 0, err = 0;
    logic [10:0] exp_word;
    for (int c = 0; c < 2000 && !init_done; c++) begin
      tick();
      host_commit = 1'b0;
      frame_start = 1'b0;
      exp_word = {1'(idx / 768), 2'((idx / 256) % 3), 8'(idx % 256)};
      if (lut_we) begin
        if ({lut_bank, lut_ch, lut_addr} !== exp_word || lut_data !== lut_addr) err++;
        idx++;
      end else err++;
    end
    chk({tag, "_writes"}, idx, 1536);
    chk({tag, "_seq_err"}, err, 0);
    chk({tag, "_done"}, init_done, 1);
    chk({tag, "_ready"}, host_ready, 1);
    tick();
    chk({tag, "_we_off"}, lut_we, 0);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_we", lut_we, 0);
    chk("rst_active", active_bank, 0);
    chk("rst_ready", host_ready, 0);
    chk("rst_done", init_done, 0);
    chk("rst_pend", commit_pending, 0);
    chk("rst_swap", swap, 0);
    rst = 1'b0;
    run_init("init1");
    host_write(2'd1, 8'h40, 8'h9A);
    chk("wr_we", lut_we, 1);
    chk("wr_bank", lut_bank, 1);
    chk("wr_ch", lut_ch, 1);
    chk("wr_addr", lut_addr, 8'h40);
    chk("wr_data", lut_data, 8'h9A);
    tick();
    chk("wr_we_drop", lut_we, 0);
    host_write(2'd3, 8'h11, 8'h22);
    chk("ch3_dropped", lut_we, 0);
    host_commit = 1'b1;
    tick();
    host_commit = 1'b0;
    chk("cm_pend", commit_pending, 1);
    chk("cm_ready", host_ready, 0);
    host_write(2'd0, 8'h05, 8'h55);
    chk("pend_wr_ignored", lut_we, 0);
    for (int i = 0; i < 8; i++) tick();
    chk("pend_active_hold", active_bank, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("sw_pulse", swap, 1);
    chk("sw_active", active_bank, 1);
    chk("sw_pend", commit_pending, 0);
    tick();
    chk("sw_pulse_end", swap, 0);
    chk("sw_ready", host_ready, 1);
    host_write(2'd2, 8'h10, 8'h33);
    chk("post_sw_bank", lut_bank, 0);
    chk("post_sw_ch", lut_ch, 2);
    host_wr = 1'b1;
    host_commit = 1'b1;
    host_ch = 2'd0;
    host_addr = 8'h80;
    host_data = 8'h01;
    tick();
    host_wr = 1'b0;
    host_commit = 1'b0;
    chk("wrcm_we", lut_we, 1);
    chk("wrcm_addr", lut_addr, 8'h80);
    chk("wrcm_pend", commit_pending, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("prst_active", active_bank, 0);
    chk("prst_pend", commit_pending, 0);
    chk("prst_done", init_done, 0);
    chk("prst_we", lut_we, 0);
    host_commit = 1'b1;
    frame_start = 1'b1;
    run_init("init2");
    chk("init2_no_pend", commit_pending, 0);
    chk("init2_active", active_bank, 0);
    host_commit = 1'b1;
    frame_start = 1'b1;
    tick();
    host_commit = 1'b0;
    frame_start = 1'b0;
    chk("same_pend", commit_pending, 1);
    chk("same_no_swap", swap, 0);
    tick();
    chk("same_active", active_bank, 0);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("next_swap", swap, 1);
    chk("next_active", active_bank, 1);
    tick();
    chk("next_ready", host_ready, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
